// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding, default width and counter sizing for the divider
package div_pkg;

   localparam int DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   // The iteration counter must hold WIDTH itself, not just WIDTH-1.
   function automatic int div_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_divider_16bit_if.sv
// rtl/seq_divider_16bit_if.sv - start/done handshake, operands and results of the divider
interface seq_divider_16bit_if #(
   parameter int WIDTH = div_pkg::DIV_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  ready, busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output ready, busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/div_add_sub_cell.sv
// rtl/div_add_sub_cell.sv - 1-bit adder/subtractor cell; i_sub inverts b before the full add
module div_add_sub_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_sub,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   logic w_b;

   assign w_b    = i_b ^ i_sub;
   assign o_sum  = i_a ^ w_b ^ i_cin;
   assign o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);

endmodule

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - ripple a - b as a + ~b + 1; no_borrow is the final carry-out
module div_trial_sub #(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             no_borrow
);

   logic [WIDTH:0] w_carry;

   assign w_carry[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      div_add_sub_cell u_cell (
         .i_a    (a[i]),
         .i_b    (b[i]),
         .i_sub  (1'b1),
         .i_cin  (w_carry[i]),
         .o_sum  (diff[i]),
         .o_cout (w_carry[i+1])
      );
   end

   assign no_borrow = w_carry[WIDTH];

endmodule

// File: rtl/seq_divider_16bit.sv
// rtl/seq_divider_16bit.sv - restoring unsigned divider, one trial subtraction per clock
module seq_divider_16bit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_divider_16bit_if.slave bus
);

   localparam int CW = div_cnt_width(WIDTH);

   div_state_e       r_state;
   div_state_e       w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic             w_accept;
   logic             w_zero_div;
   logic             w_last_iter;
   logic             w_no_borrow;
   logic [WIDTH:0]   w_shift_rem;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quo_next;
   logic             w_unused_diff_msb;

   assign w_accept    = (r_state == ST_IDLE) && bus.start;
   assign w_zero_div  = (bus.divisor == '0);
   assign w_last_iter = (r_cnt == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_next = w_zero_div ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (w_last_iter) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // {R,Q} shifted left: the partial remainder gains Q's MSB and grows to WIDTH+1 bits,
   // since it can reach 2*divisor-1 before the trial subtraction.
   assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};

   div_trial_sub #(
      .WIDTH (WIDTH + 1)
   ) u_trial (
      .a         (w_shift_rem),
      .b         ({1'b0, r_divisor}),
      .diff      (w_diff),
      .no_borrow (w_no_borrow)
   );

   // A restored remainder is always below the divisor, so its top bit is zero.
   assign w_unused_diff_msb = w_diff[WIDTH];
   assign w_rem_next = w_no_borrow ? w_diff[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
   assign w_quo_next = {r_quo[WIDTH-2:0], w_no_borrow};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_divisor   <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         if (w_accept && !w_zero_div) begin
            r_cnt     <= CW'(WIDTH);
            r_rem     <= '0;
            r_quo     <= bus.dividend;
            r_divisor <= bus.divisor;
         end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt - CW'(1);
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
         end

         // Results change only on entry to DONE and hold until the next one.
         if (w_accept && w_zero_div) begin
            r_quotient  <= '1;
            r_remainder <= bus.dividend;
            r_dbz       <= 1'b1;
         end else if ((r_state == ST_CALC) && w_last_iter) begin
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next;
            r_dbz       <= 1'b0;
         end
      end
   end

   assign bus.ready       = (r_state == ST_IDLE);
   assign bus.busy        = (r_state == ST_CALC);
   assign bus.done        = (r_state == ST_DONE);
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;

endmodule
